// File: rtl/alu_bennett_sequencer_pkg.sv
// Shared types for the adiabatic ALU sequencer: opcodes, FSM states and the
// bundle of ALU select lines.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_SLT     = 3'd2,
        OP_AND     = 3'd3,
        OP_OR      = 3'd4,
        OP_PCINC   = 3'd5,
        OP_IMM     = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        EVAL,
        FIRE,
        CAPTURE,
        DRAIN,
        DONE
    } state_e;

    // Field order matches {C1C0, A_mux, B_mux1B_mux0, SUB, STL, Cin, mux3_1mux3_0}
    typedef struct packed {
        logic alu_control1;
        logic alu_control0;
        logic a_mux;
        logic b_mux1;
        logic b_mux0;
        logic sub;
        logic stl;
        logic adder_cin;
        logic mux3_1;
        logic mux3_0;
    } alu_ctrl_t;

    localparam alu_ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/alu_bennett_sequencer_decode.sv
// Opcode to ALU select-line decode; purely combinational, registered by the FSM.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  op_e       op,
    output alu_ctrl_t ctrl
);

    // Map each legal opcode onto its select pattern; illegal maps to idle
    always_comb begin
        ctrl = CTRL_IDLE;
        case (op)
            OP_ADD:   ctrl = alu_ctrl_t'(10'b10_1_11_0_0_0_00);
            OP_SUB:   ctrl = alu_ctrl_t'(10'b10_1_11_1_0_1_00);
            OP_SLT:   ctrl = alu_ctrl_t'(10'b10_1_11_1_1_1_00);
            OP_AND:   ctrl = alu_ctrl_t'(10'b00_1_11_0_0_0_00);
            OP_OR:    ctrl = alu_ctrl_t'(10'b01_1_11_0_0_0_00);
            OP_PCINC: ctrl = alu_ctrl_t'(10'b10_0_00_0_0_1_01);
            OP_IMM:   ctrl = alu_ctrl_t'(10'b11_1_10_0_0_0_10);
            default:  ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/alu_bennett_sequencer.sv
// Sequences one ALU operation per Bennett clock cycle: holds selects/operands,
// fires the slow-clock latch pulses while all rails are charged, captures the
// result and releases the controls after discharge.
module alu_bennett_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 13,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instFlag,
    input  logic [WIDTH-1:0]  clkpos,
    input  logic [WIDTH-1:0]  clkneg,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] op_pc,
    input  logic [DATA_W-1:0] op_instr,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] PC_in,
    output logic [DATA_W-1:0] instr_in,
    output logic              ALU_Control0,
    output logic              ALU_Control1,
    output logic              A_mux,
    output logic              Adder_Cin,
    output logic              B_mux0,
    output logic              B_mux1,
    output logic              SUB,
    output logic              STL,
    output logic              mux3_0,
    output logic              mux3_1,
    output logic              ALU_O_Fclkpos,
    output logic              A_Fclkpos,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              out_Zero_Detect,
    output logic              res_valid,
    output logic [DATA_W-1:0] result,
    output logic              res_zero,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state;
    alu_ctrl_t        ctrl_q;
    alu_ctrl_t        dec_ctrl;
    logic             fire_q;
    logic             flag_q;
    logic [CNT_W-1:0] cnt;
    logic             charged;
    logic             flag_rise;

    alu_op_decode u_decode (
        .op   (op_e'(op_code)),
        .ctrl (dec_ctrl)
    );

    assign charged   = (clkpos == '1) && (clkneg == '0);
    assign flag_rise = instFlag && !flag_q;

    assign ALU_Control1  = ctrl_q.alu_control1;
    assign ALU_Control0  = ctrl_q.alu_control0;
    assign A_mux         = ctrl_q.a_mux;
    assign B_mux1        = ctrl_q.b_mux1;
    assign B_mux0        = ctrl_q.b_mux0;
    assign SUB           = ctrl_q.sub;
    assign STL           = ctrl_q.stl;
    assign Adder_Cin     = ctrl_q.adder_cin;
    assign mux3_1        = ctrl_q.mux3_1;
    assign mux3_0        = ctrl_q.mux3_0;
    assign ALU_O_Fclkpos = fire_q;
    assign A_Fclkpos     = fire_q;

    // Sequencer FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ctrl_q    <= CTRL_IDLE;
            a         <= '0;
            b         <= '0;
            PC_in     <= '0;
            instr_in  <= '0;
            fire_q    <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            res_zero  <= 1'b0;
            op_ready  <= 1'b1;
            busy      <= 1'b0;
            flag_q    <= 1'b0;
            cnt       <= '0;
        end else begin
            flag_q    <= instFlag;
            fire_q    <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (op_e'(op_code) == OP_ILLEGAL) begin
                            err <= 1'b1;
                        end else begin
                            ctrl_q   <= dec_ctrl;
                            a        <= op_a;
                            b        <= op_b;
                            PC_in    <= op_pc;
                            instr_in <= op_instr;
                            op_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ARM;
                        end
                    end
                end
                ARM: begin
                    if (flag_rise) begin
                        cnt   <= '0;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (charged) begin
                        fire_q <= 1'b1;
                        state  <= FIRE;
                    end else if (cnt == CNT_LAST) begin
                        err      <= 1'b1;
                        ctrl_q   <= CTRL_IDLE;
                        a        <= '0;
                        b        <= '0;
                        PC_in    <= '0;
                        instr_in <= '0;
                        op_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIRE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    result   <= alu_out;
                    res_zero <= out_Zero_Detect;
                    state    <= DRAIN;
                end
                DRAIN: begin
                    // Controls drop together with res_valid so DONE already shows defaults
                    if (flag_rise) begin
                        res_valid <= 1'b1;
                        ctrl_q    <= CTRL_IDLE;
                        a         <= '0;
                        b         <= '0;
                        PC_in     <= '0;
                        instr_in  <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    op_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bennett_sequencer.sv
// Directed bench for alu_bennett_sequencer with a small behavioural ALU.
module tb_alu_bennett_sequencer;

    localparam int WIDTH       = 13;
    localparam int DATA_W      = 16;
    localparam int TIMEOUT_CYC = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              instFlag;
    logic [WIDTH-1:0]  clkpos;
    logic [WIDTH-1:0]  clkneg;
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [DATA_W-1:0] op_a, op_b, op_pc, op_instr;
    logic [DATA_W-1:0] a, b, PC_in, instr_in;
    logic              ALU_Control0, ALU_Control1, A_mux, Adder_Cin, B_mux0, B_mux1;
    logic              SUB, STL, mux3_0, mux3_1;
    logic              ALU_O_Fclkpos, A_Fclkpos;
    logic [DATA_W-1:0] alu_out;
    logic              out_Zero_Detect;
    logic              res_valid;
    logic [DATA_W-1:0] result;
    logic              res_zero;
    logic              err;
    logic              busy;

    logic [9:0]        sel_obs;
    int                n_checks = 0;
    int                n_errors = 0;
    int                fire_cnt = 0;
    int                fire_bad = 0;
    int                rv_cnt   = 0;
    int                err_cnt  = 0;

    alu_bennett_sequencer #(
        .WIDTH       (WIDTH),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instFlag        (instFlag),
        .clkpos          (clkpos),
        .clkneg          (clkneg),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_code         (op_code),
        .op_a            (op_a),
        .op_b            (op_b),
        .op_pc           (op_pc),
        .op_instr        (op_instr),
        .a               (a),
        .b               (b),
        .PC_in           (PC_in),
        .instr_in        (instr_in),
        .ALU_Control0    (ALU_Control0),
        .ALU_Control1    (ALU_Control1),
        .A_mux           (A_mux),
        .Adder_Cin       (Adder_Cin),
        .B_mux0          (B_mux0),
        .B_mux1          (B_mux1),
        .SUB             (SUB),
        .STL             (STL),
        .mux3_0          (mux3_0),
        .mux3_1          (mux3_1),
        .ALU_O_Fclkpos   (ALU_O_Fclkpos),
        .A_Fclkpos       (A_Fclkpos),
        .alu_out         (alu_out),
        .out_Zero_Detect (out_Zero_Detect),
        .res_valid       (res_valid),
        .result          (result),
        .res_zero        (res_zero),
        .err             (err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    assign sel_obs = {ALU_Control1, ALU_Control0, A_mux, B_mux1, B_mux0,
                      SUB, STL, Adder_Cin, mux3_1, mux3_0};

    // Behavioural ALU driven by the held selects and operands
    always_comb begin
        alu_out = '0;
        case ({ALU_Control1, ALU_Control0})
            2'b10: begin
                if (!A_mux)   alu_out = PC_in + 16'd1;
                else if (STL) alu_out = {15'd0, $signed(a) < $signed(b)};
                else if (SUB) alu_out = a - b;
                else          alu_out = a + b;
            end
            2'b00: alu_out = a & b;
            2'b01: alu_out = a | b;
            default: alu_out = instr_in;
        endcase
        out_Zero_Detect = (alu_out == '0);
    end

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (ALU_O_Fclkpos) begin
            fire_cnt++;
            if (!((clkpos == '1) && (clkneg == '0))) fire_bad++;
        end
        if (res_valid) rv_cnt++;
        if (err) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sel"},   {22'd0, sel_obs}, 32'd0);
        check({tag, "_fclk"},  {30'd0, ALU_O_Fclkpos, A_Fclkpos}, 32'd0);
        check({tag, "_opnds"}, {a | b, PC_in | instr_in}, 32'd0);
        check({tag, "_flags"}, {28'd0, res_valid, err, busy, res_zero}, 32'd0);
        check({tag, "_result"}, {16'd0, result}, 32'd0);
        check({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
    endtask

    // abort_at: 0 = complete, 1 = reset in FIRE, 2 = reset in DRAIN
    task automatic run_op(input logic [2:0] code, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] vpc, input logic [15:0] vinstr,
                          input logic [9:0] exp_sel, input logic [15:0] exp_res,
                          input logic exp_zero, input bit hold_valid, input int abort_at);
        int fire0;
        int rv0;
        fire0 = fire_cnt;
        rv0   = rv_cnt;
        op_code = code; op_a = va; op_b = vb; op_pc = vpc; op_instr = vinstr;
        op_valid = 1'b1;
        check("ready_before", {31'd0, op_ready}, 32'd1);
        tick();
        check("ready_busy", {30'd0, op_ready, busy}, 32'd1);
        check("sel_arm", {22'd0, sel_obs}, {22'd0, exp_sel});
        check("opnd_arm", {a, b}, {va, vb});
        if (!hold_valid) op_valid = 1'b0;
        tick();
        check("arm_waits", {31'd0, ALU_O_Fclkpos}, 32'd0);
        instFlag = 1'b1;
        tick();
        instFlag = 1'b0;
        tick();
        check("fire", {30'd0, ALU_O_Fclkpos, A_Fclkpos}, 32'd3);
        if (abort_at == 1) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_reset_state("rst_fire");
            tick();
            check("rst_fire_norv", rv_cnt - rv0, 0);
            return;
        end
        tick();
        check("fire_once", {31'd0, ALU_O_Fclkpos}, 32'd0);
        tick();
        check("result", {15'd0, res_zero, result}, {15'd0, exp_zero, exp_res});
        check("sel_drain", {22'd0, sel_obs}, {22'd0, exp_sel});
        tick();
        check("drain_waits", {30'd0, res_valid, op_ready}, 32'd0);
        if (abort_at == 2) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_reset_state("rst_drain");
            instFlag = 1'b1;
            tick();
            instFlag = 1'b0;
            tick();
            tick();
            check("rst_drain_norv", rv_cnt - rv0, 0);
            return;
        end
        instFlag = 1'b1;
        tick();
        instFlag = 1'b0;
        check("done_rv", {31'd0, res_valid}, 32'd1);
        check("done_sel", {22'd0, sel_obs}, 32'd0);
        check("done_ready", {30'd0, op_ready, busy}, 32'd1);
        tick();
        check("idle_back", {29'd0, res_valid, op_ready, busy}, 32'd2);
        check("fire_count", fire_cnt - fire0, 1);
        check("rv_count", rv_cnt - rv0, 1);
    endtask

    initial begin
        int tcount;
        int fire0;
        int rv0;
        int err0;
        reset = 1'b1; instFlag = 1'b0; clkpos = '1; clkneg = '0;
        op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0; op_pc = '0; op_instr = '0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        run_op(3'd0, 16'd1, 16'd2, 16'd0, 16'd0, 10'b10_1_11_0_0_0_00, 16'd3, 1'b0, 1'b0, 0);
        run_op(3'd1, 16'd5, 16'd5, 16'd0, 16'd0, 10'b10_1_11_1_0_1_00, 16'd0, 1'b1, 1'b0, 0);
        run_op(3'd0, 16'd7, 16'd8, 16'd0, 16'd0, 10'b10_1_11_0_0_0_00, 16'd15, 1'b0, 1'b1, 0);
        run_op(3'd4, 16'h00F0, 16'h000F, 16'd0, 16'd0, 10'b01_1_11_0_0_0_00, 16'h00FF, 1'b0, 1'b1, 0);
        op_valid = 1'b0;
        run_op(3'd2, 16'd3, 16'd5, 16'd0, 16'd0, 10'b10_1_11_1_1_1_00, 16'd1, 1'b0, 1'b0, 0);
        run_op(3'd3, 16'h0F0F, 16'h00FF, 16'd0, 16'd0, 10'b00_1_11_0_0_0_00, 16'h000F, 1'b0, 1'b0, 0);
        run_op(3'd5, 16'd0, 16'd0, 16'h0041, 16'd0, 10'b10_0_00_0_0_1_01, 16'h0042, 1'b0, 1'b0, 0);
        run_op(3'd6, 16'd0, 16'd0, 16'd0, 16'h1234, 10'b11_1_10_0_0_0_10, 16'h1234, 1'b0, 1'b0, 0);
        check("no_err_normal", err_cnt, 0);

        // Charge timeout
        fire0 = fire_cnt; rv0 = rv_cnt; err0 = err_cnt;
        op_code = 3'd0; op_a = 16'd1; op_b = 16'd1; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        clkpos = '0;
        instFlag = 1'b1;
        tick();
        instFlag = 1'b0;
        tcount = 0;
        for (int k = 1; k <= TIMEOUT_CYC + 40; k++) begin
            if (k == 10) instFlag = 1'b1;
            if (k == 11) instFlag = 1'b0;
            tick();
            if (err) begin
                tcount = k;
                break;
            end
        end
        check("timeout_cycles", tcount, TIMEOUT_CYC);
        check("timeout_ready", {30'd0, op_ready, busy}, 32'd2);
        check("timeout_sel", {22'd0, sel_obs}, 32'd0);
        check("timeout_opnd", {a, b}, 32'd0);
        tick();
        check("timeout_err_pulse", {31'd0, err}, 32'd0);
        check("timeout_nofire", fire_cnt - fire0, 0);
        check("timeout_norv", rv_cnt - rv0, 0);
        check("timeout_errcnt", err_cnt - err0, 1);
        clkpos = '1;

        // Illegal opcode
        fire0 = fire_cnt; err0 = err_cnt;
        op_code = 3'd7; op_a = 16'h5555; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        check("illegal_err", {29'd0, err, op_ready, busy}, 32'd6);
        check("illegal_nolatch", {16'd0, a}, 32'd0);
        tick();
        check("illegal_pulse", {31'd0, err}, 32'd0);
        tick();
        check("illegal_errcnt", err_cnt - err0, 1);
        check("illegal_nofire", fire_cnt - fire0, 0);

        // Reset aborts, then recovery
        run_op(3'd0, 16'd9, 16'd9, 16'd0, 16'd0, 10'b10_1_11_0_0_0_00, 16'd18, 1'b0, 1'b0, 1);
        run_op(3'd0, 16'd9, 16'd9, 16'd0, 16'd0, 10'b10_1_11_0_0_0_00, 16'd18, 1'b0, 1'b0, 2);
        run_op(3'd0, 16'd0, 16'd0, 16'd0, 16'd0, 10'b10_1_11_0_0_0_00, 16'd0, 1'b1, 1'b0, 0);
        check("fire_while_charged", fire_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
